multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Main control FSM for the multicycle MIPS datapath. It sits directly upstream of alu_decoder.
- Decodes the 6-bit opcode and sequences fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select, plus the 2-bit ALUOp that alu_decoder expands with Funct.
- Handles a variable-latency memory through a ready handshake, with a bounded wait.

Parameters:
- MEM_TIMEOUT, 255: cycles spent waiting on mem_ready before the access is abandoned; legal range 1..255; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- Opcode  input  6  instr[31:26] from IR; stable from DECODE until FETCH is re-entered
- mem_ready  input  1  memory completes the current access this cycle
- PCWrite  output  1  unconditional PC write
- Branch  output  1  PC write qualified by Zero, external AND/OR
- IorD  output  1  memory address source: 0=PC, 1=ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- RegDst  output  1  destination register: 0=rt, 1=rd
- MemtoReg  output  1  writeback data: 0=ALUOut, 1=MDR
- RegWrite  output  1  register file write
- ALUSrcA  output  1  ALU A input: 0=PC, 1=A register
- ALUSrcB  output  2  ALU B input: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
- ALUOp  output  2  to alu_decoder: 00=add, 01=sub, 10=use Funct
- PCSrc  output  2  next-PC select: 00=ALUResult, 01=ALUOut, 10=jump target
- instr_done  output  1  one-cycle pulse in the final cycle of each instruction
- mem_timeout  output  1  one-cycle pulse when a memory wait is abandoned

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset: state=FETCH and wait counter=0. While rst=1, PCWrite, Branch, MemWrite, IRWrite, RegWrite, instr_done and mem_timeout are forced 0; the selects take their FETCH values.
- Moore outputs: outputs are decoded from the registered state only. The exceptions are the qualified strobes noted below, which gate on mem_ready combinationally. Any signal not listed for a state is 0.
- Opcodes: LW=100011, SW=101011, RTYPE=000000, BEQ=000100, ADDI=001000, J=000010.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite=PCWrite=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode: LW/SW->MEMADR, RTYPE->EXECUTE, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP, any other->see Optional Feature.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: IorD=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Go to FETCH.
- MEMWR: IorD=1, MemWrite=1, held until mem_ready. On mem_ready: instr_done=1, go to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- ALUWB: RegDst=1, RegWrite=1, instr_done=1. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, instr_done=1. Go to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDIWB.
- ADDIWB: RegDst=0, RegWrite=1, instr_done=1. Go to FETCH.
- JUMP: PCSrc=10, PCWrite=1, instr_done=1. Go to FETCH.
- Latency with mem_ready held at 1, in cycles: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3.
- Wait counter (8-bit):
  - Increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
  - Clears on any state change, and in any cycle where mem_ready=1.
  - When the counter equals MEM_TIMEOUT (MEM_TIMEOUT!=0) and mem_ready=0: pulse mem_timeout, suppress all strobes that cycle, go to FETCH.
  - An abandoned access writes nothing and leaves PC unchanged.
- Precedence: if mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT, mem_ready wins and no timeout occurs.
- Reset mid-instruction: the FSM returns to FETCH immediately and all strobes drop asynchronously.

Optional Feature:
- Macro: CTRL_ILLEGAL_OP_EN.
- Defined:
  - Adds output illegal_op (1 bit).
  - An unknown opcode in DECODE goes to state TRAP.
  - TRAP: illegal_op=1, every other strobe 0, instr_done=0. TRAP is left only by rst.
- Undefined:
  - There is no illegal_op port.
  - An unknown opcode is treated as a NOP: DECODE pulses instr_done and goes to FETCH.

Test Plan:
- Reset, then LW (100011) with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 and MemtoReg=1 only in cycle 5; instr_done pulses once.
- RTYPE (000000) -> ALUOp=10 in cycle 3 only; RegDst=1 and RegWrite=1 in cycle 4. BEQ (000100) -> cycle 3: ALUOp=01, Branch=1, PCSrc=01.
- SW with mem_ready low for 3 cycles in MEMWR -> MemWrite held high for 4 cycles; instr_done in the cycle mem_ready=1; total 7 cycles.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> mem_timeout pulses on the 5th waiting cycle; IRWrite and PCWrite never assert; FSM stays in FETCH; counter back to 0.
- rst asserted mid-cycle in MEMWR -> MemWrite drops without waiting for a clock edge; after release, FETCH with ALUSrcB=01.
- Opcode 111111: with CTRL_ILLEGAL_OP_EN -> illegal_op=1 persists until rst. Without it -> instr_done pulses in cycle 2, then FETCH.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle MIPS main controller and its datapath.
//
// Signals
//   Opcode      instr[31:26] from IR, datapath -> controller
//   mem_ready   memory completes the current access, memory -> controller
//   PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0]
//               datapath enables and mux selects, controller -> datapath
//   instr_done  one-cycle pulse in the last cycle of an instruction
//   mem_timeout one-cycle pulse when a memory wait is abandoned
//   illegal_op  present only when CTRL_ILLEGAL_OP_EN is defined
//
// Modports: master = controller side, slave = datapath side.
// Optional macro: CTRL_ILLEGAL_OP_EN adds illegal_op.
interface multicycle_controller_if;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       Branch;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       instr_done;
  logic       mem_timeout;
`ifdef CTRL_ILLEGAL_OP_EN
  logic       illegal_op;

  modport master (
    input  Opcode, mem_ready,
    output PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, instr_done, mem_timeout, illegal_op
  );
  modport slave (
    output Opcode, mem_ready,
    input  PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, instr_done, mem_timeout, illegal_op
  );
`else
  modport master (
    input  Opcode, mem_ready,
    output PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, instr_done, mem_timeout
  );
  modport slave (
    output Opcode, mem_ready,
    input  PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, instr_done, mem_timeout
  );
`endif
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath (feeds alu_decoder).
// Sequences fetch/decode/execute/memory/writeback from the 6-bit opcode and
// drives every datapath enable and mux select. Memory accesses wait on
// mem_ready, bounded by MEM_TIMEOUT cycles (0 = wait forever).
//
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  multicycle_controller_if.master (opcode/mem_ready in, controls out)
//
// Optional macro: CTRL_ILLEGAL_OP_EN -- unknown opcodes trap in TRAP and
// raise illegal_op until reset; otherwise they retire as a NOP in DECODE.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_controller_if.master  bus
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [7:0] TO_LIMIT = 8'(MEM_TIMEOUT);
  localparam bit         TO_EN    = (MEM_TIMEOUT != 0);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wait_st;
  logic       timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = '0;
    bus.PCWrite      = 1'b0;
    bus.Branch       = 1'b0;
    bus.IorD         = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.RegDst       = 1'b0;
    bus.MemtoReg     = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.ALUSrcA      = 1'b0;
    bus.ALUSrcB      = 2'b00;
    bus.ALUOp        = 2'b00;
    bus.PCSrc        = 2'b00;
    bus.instr_done   = 1'b0;
`ifdef CTRL_ILLEGAL_OP_EN
    bus.illegal_op   = 1'b0;
`endif
    wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // A ready in the limit cycle completes the access rather than timing out.
    timeout = TO_EN && wait_st && !bus.mem_ready && (cnt_q == TO_LIMIT);

    case (state_q)
      S_FETCH: begin
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef CTRL_ILLEGAL_OP_EN
          default:      state_d = S_TRAP;
`else
          default: begin
            bus.instr_done = 1'b1;
            state_d        = S_FETCH;
          end
`endif
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.IorD = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.MemtoReg   = 1'b1;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWR: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
      end
      S_EXECUTE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegDst     = 1'b1;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUOp      = 2'b01;
        bus.PCSrc      = 2'b01;
        bus.Branch     = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        bus.PCSrc      = 2'b10;
        bus.PCWrite    = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
`ifdef CTRL_ILLEGAL_OP_EN
      S_TRAP: bus.illegal_op = 1'b1;
`endif
      default: state_d = S_FETCH;
    endcase

    // Wait states only loop on themselves while mem_ready is low, so the
    // counter is zero on entry; saturate so a disabled timeout never wraps.
    if (wait_st && !bus.mem_ready && !timeout) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end

    // Abandoned access: nothing is written and the PC is left alone.
    if (timeout) begin
      bus.PCWrite    = 1'b0;
      bus.Branch     = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.instr_done = 1'b0;
      state_d        = S_FETCH;
    end
    bus.mem_timeout = timeout && !rst;

    // state_q already reads FETCH during reset; the FETCH strobes follow
    // mem_ready combinationally, so they are killed here as well.
    if (rst) begin
      bus.PCWrite    = 1'b0;
      bus.Branch     = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.instr_done = 1'b0;
    end
  end

endmodule
